// File: rtl/mem_bus_arbiter_pkg.sv
// Shared state encodings, reset polarity and sizing helpers for the memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_ACC  = 2'd1,
    ST_MEM_ACC = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_t;

  localparam logic RST_ACTIVE  = 1'b1;
  localparam int   DEF_ADDR_W  = 32;
  localparam int   DEF_DATA_W  = 32;
  localparam int   DEF_TIMEOUT = 255;

  function automatic int wd_cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side (IF/MEM), bus-side and stall signals of the memory bus arbiter.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic                mem_req;
  logic                mem_we;
  logic [DATA_W/8-1:0] mem_sel;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ack;

  logic                bus_err;
  logic                bus_cyc;
  logic                bus_we;
  logic [DATA_W/8-1:0] bus_sel;
  logic [ADDR_W-1:0]   bus_addr;
  logic [DATA_W-1:0]   bus_wdata;
  logic [DATA_W-1:0]   bus_rdata;
  logic                bus_ack;

  logic stallreq_if;
  logic stallreq_mem;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
           bus_rdata, bus_ack,
    output if_rdata, if_ack, mem_rdata, mem_ack, bus_err,
           bus_cyc, bus_we, bus_sel, bus_addr, bus_wdata,
           stallreq_if, stallreq_mem
  );

  // Pipeline/slave side.
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
           bus_rdata, bus_ack,
    input  if_rdata, if_ack, mem_rdata, mem_ack, bus_err,
           bus_cyc, bus_we, bus_sel, bus_addr, bus_wdata,
           stallreq_if, stallreq_mem
  );
endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// Bus access watchdog: counts waiting cycles and flags the TIMEOUT-th one.
module mem_bus_arbiter_watchdog
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = wd_cnt_w(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE || clear) count <= '0;
    else if (enable)                count <= count + CNT_W'(1);
  end

  // Asserted during the cycle that would be the TIMEOUT-th without bus_ack.
  assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and load/store.
// state    | meaning
// IDLE     | no transaction; grant MEM before IF
// IF_ACC   | fetch transaction on the bus, waiting for bus_ack or timeout
// MEM_ACC  | load/store transaction on the bus, waiting for bus_ack or timeout
// RESP     | owner ack visible; requester drops req, no grant this cycle
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic            clk,
  input logic            rst,
  mem_bus_arbiter_if.slave arb
);

  localparam int SEL_W = DATA_W / 8;

  arb_state_t        state_q, state_d;
  logic              cyc_q, cyc_d, we_q, we_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic              if_ack_q, if_ack_d, mem_ack_q, mem_ack_d, err_q, err_d;
  logic              wd_clear, wd_en, wd_expired;

  mem_bus_arbiter_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    err_d       = 1'b0;
    wd_clear    = 1'b0;
    wd_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // MEM wins: it belongs to the older instruction in the pipeline.
        if (arb.mem_req) begin
          cyc_d    = 1'b1;
          we_d     = arb.mem_we;
          sel_d    = arb.mem_sel;
          addr_d   = arb.mem_addr;
          wdata_d  = arb.mem_wdata;
          wd_clear = 1'b1;
          state_d  = ST_MEM_ACC;
        end else if (arb.if_req) begin
          cyc_d    = 1'b1;
          we_d     = 1'b0;
          sel_d    = '1;
          addr_d   = arb.if_addr;
          wdata_d  = '0;
          wd_clear = 1'b1;
          state_d  = ST_IF_ACC;
        end
      end
      ST_IF_ACC, ST_MEM_ACC: begin
        wd_en = !arb.bus_ack;
        if (arb.bus_ack || wd_expired) begin
          cyc_d   = 1'b0;
          err_d   = !arb.bus_ack;
          state_d = ST_RESP;
          if (state_q == ST_MEM_ACC) begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = arb.bus_ack ? arb.bus_rdata : '0;
          end else begin
            if_ack_d    = 1'b1;
            if_rdata_d  = arb.bus_ack ? arb.bus_rdata : '0;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign arb.bus_cyc      = cyc_q;
  assign arb.bus_we       = we_q;
  assign arb.bus_sel      = sel_q;
  assign arb.bus_addr     = addr_q;
  assign arb.bus_wdata    = wdata_q;
  assign arb.if_rdata     = if_rdata_q;
  assign arb.mem_rdata    = mem_rdata_q;
  assign arb.if_ack       = if_ack_q;
  assign arb.mem_ack      = mem_ack_q;
  assign arb.bus_err      = err_q;
  assign arb.stallreq_if  = arb.if_req & ~if_ack_q;
  assign arb.stallreq_mem = arb.mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: one pending request per port, its attributes.
  bit          if_pend, mem_pend;
  logic [31:0] m_if_addr, m_mem_addr, m_mem_wdata;
  logic        m_mem_we;
  logic [3:0]  m_mem_sel;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) arb ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .arb (arb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic post_if(input logic [31:0] addr);
    if_pend = 1'b1; m_if_addr = addr;
    arb.if_req = 1'b1; arb.if_addr = addr;
  endtask

  task automatic post_mem(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] wdata);
    mem_pend = 1'b1; m_mem_we = we; m_mem_sel = sel; m_mem_addr = addr; m_mem_wdata = wdata;
    arb.mem_req = 1'b1; arb.mem_we = we; arb.mem_sel = sel;
    arb.mem_addr = addr; arb.mem_wdata = wdata;
  endtask

  // One arbitration round from IDLE; slave answers 'lat' cycles after bus_cyc rises.
  task automatic run_round(input int lat, input logic [31:0] rdata, input bit late_ack);
    bit          win_mem, err;
    int          acc;
    logic [31:0] e_addr, e_wdata, e_rd;
    logic        e_we;
    logic [3:0]  e_sel;
    win_mem = mem_pend;
    e_addr  = win_mem ? m_mem_addr  : m_if_addr;
    e_we    = win_mem ? m_mem_we    : 1'b0;
    e_sel   = win_mem ? m_mem_sel   : 4'hF;
    e_wdata = win_mem ? m_mem_wdata : 32'h0;
    err     = (lat + 1 > TIMEOUT);
    acc     = err ? TIMEOUT : lat + 1;
    e_rd    = err ? 32'h0 : rdata;

    @(posedge clk); #1;
    chk("grant_cyc", arb.bus_cyc, 1'b1);
    chk("grant_addr", arb.bus_addr, e_addr);
    chk("grant_we", arb.bus_we, e_we);
    chk("grant_sel", arb.bus_sel, e_sel);
    chk("grant_wdata", arb.bus_wdata, e_wdata);
    chk("grant_stall_if", arb.stallreq_if, if_pend);
    chk("grant_stall_mem", arb.stallreq_mem, mem_pend);

    for (int c = 1; c <= acc; c++) begin
      arb.bus_ack   = (c == lat + 1);
      arb.bus_rdata = arb.bus_ack ? rdata : $urandom;
      @(posedge clk); #1;
      arb.bus_ack = 1'b0;
      if (c < acc) begin
        chk("acc_cyc", arb.bus_cyc, 1'b1);
        chk("acc_hold_addr", arb.bus_addr, e_addr);
        chk("acc_no_ack", {arb.if_ack, arb.mem_ack}, 2'b00);
      end
    end

    chk("done_cyc", arb.bus_cyc, 1'b0);
    chk("done_acks", {arb.mem_ack, arb.if_ack}, win_mem ? 2'b10 : 2'b01);
    chk("done_rdata", win_mem ? arb.mem_rdata : arb.if_rdata, e_rd);
    chk("done_err", arb.bus_err, err);
    chk("done_stall_if", arb.stallreq_if, win_mem ? if_pend : 1'b0);
    chk("done_stall_mem", arb.stallreq_mem, 1'b0);

    if (win_mem) begin mem_pend = 1'b0; arb.mem_req = 1'b0; end
    else         begin if_pend  = 1'b0; arb.if_req  = 1'b0; end
    arb.bus_ack   = late_ack;
    arb.bus_rdata = $urandom;
    @(posedge clk); #1;
    arb.bus_ack = 1'b0;
    chk("resp_cyc", arb.bus_cyc, 1'b0);
    chk("resp_acks", {arb.mem_ack, arb.if_ack, arb.bus_err}, 3'b000);
    chk("resp_rdata_hold", win_mem ? arb.mem_rdata : arb.if_rdata, e_rd);
  endtask

  initial begin
    arb.if_req = 0; arb.if_addr = 0; arb.mem_req = 0; arb.mem_we = 0; arb.mem_sel = 0;
    arb.mem_addr = 0; arb.mem_wdata = 0; arb.bus_rdata = 0; arb.bus_ack = 0;
    if_pend = 0; mem_pend = 0;
    m_if_addr = 0; m_mem_addr = 0; m_mem_wdata = 0; m_mem_we = 0; m_mem_sel = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cyc", arb.bus_cyc, 1'b0);
    chk("rst_attr", {arb.bus_we, arb.bus_sel}, 5'h0);
    chk("rst_addr", arb.bus_addr, 32'h0);
    chk("rst_wdata", arb.bus_wdata, 32'h0);
    chk("rst_rdata", arb.if_rdata | arb.mem_rdata, 32'h0);
    chk("rst_acks", {arb.if_ack, arb.mem_ack, arb.bus_err}, 3'b000);
    rst = 1'b0;

    // Fetch, two-cycle slave.
    post_if(32'h100);
    run_round(2, 32'h3C01_0001, 1'b0);
    // Zero-wait store.
    post_mem(1'b1, 4'b0011, 32'h2004, 32'hDEAD_BEEF);
    run_round(0, 32'h1234_5678, 1'b0);
    // Conflict: MEM first, then IF after RESP.
    post_if(32'h400);
    post_mem(1'b0, 4'hF, 32'h3000, 32'h0);
    run_round(1, 32'hAAAA_5555, 1'b0);
    run_round(0, 32'h5555_AAAA, 1'b0);
    // Timeout with late ack, then ack coincident with expiry.
    post_mem(1'b0, 4'hF, 32'h5000, 32'h0);
    run_round(20, 32'hFFFF_FFFF, 1'b1);
    post_mem(1'b0, 4'hF, 32'h5004, 32'h0);
    run_round(TIMEOUT - 1, 32'hC0FF_EE00, 1'b0);
    post_if(32'h104);
    run_round(TIMEOUT, 32'h1111_1111, 1'b1);

    // Reset in the middle of a fetch.
    post_if(32'h200);
    @(posedge clk); #1;
    chk("pre_rst_cyc", arb.bus_cyc, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_cyc", arb.bus_cyc, 1'b0);
    chk("midrst_acks", {arb.if_ack, arb.mem_ack, arb.bus_err}, 3'b000);
    chk("midrst_addr", arb.bus_addr, 32'h0);
    chk("midrst_sel", arb.bus_sel, 4'h0);
    chk("midrst_rdata", arb.if_rdata | arb.mem_rdata, 32'h0);
    chk("midrst_stall_if", arb.stallreq_if, 1'b1);
    rst = 1'b0;
    run_round(1, 32'h2222_3333, 1'b0);

    for (int r = 0; r < 60; r++) begin
      if (!if_pend && $urandom_range(0, 1) == 1) post_if($urandom);
      if (!mem_pend && $urandom_range(0, 1) == 1)
        post_mem($urandom_range(0, 1) == 1, 4'($urandom), $urandom, $urandom);
      if (!if_pend && !mem_pend) post_if($urandom);
      run_round($urandom_range(0, TIMEOUT + 2), $urandom, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
